im_fu_iter: RTL and testbench

//  Parametrised iterative RV32M/RV64M integer multiplier (MUL/MULH/MULHSU/MULHU) for the EXE stage.

---
 rtl/im_fu_iter.sv | 202 ++++++++++++++++++++
 tb/tb_im_fu_iter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fu_iter.sv
// Iterative RV32M/RV64M multiplier for EXE: MUL/MULH/MULHSU/MULHU,
// BPC multiplier bits per cycle, flush abort and last-product reuse.
module im_fu_iter #(
  parameter int XLEN     = 32,
  parameter int BPC      = 4,
  parameter bit EN_REUSE = 1'b1
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] rd_out,
  output logic            busy_out
);

  localparam int N  = XLEN / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * XLEN;
  localparam int AW = PW + BPC;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  if (XLEN % BPC != 0) begin : g_bad_cfg
    $error("im_fu_iter: XLEN must be a multiple of BPC");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] a2_q;
  logic [PW-1:0]   m_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   acc_q;
  logic [XLEN-1:0] rd_q;
  logic            vld_q;

  logic            re_v_q;
  logic [XLEN-1:0] re_rs1_q;
  logic [XLEN-1:0] re_rs2_q;
  logic [1:0]      re_op_q;
  logic [PW-1:0]   re_p_q;

  logic [XLEN-1:0] a1_d;
  logic [XLEN-1:0] a2_d;
  logic            neg_d;
  logic            accept;
  logic            zero;
  logic            hit;
  logic [XLEN-1:0] re_sel;
  logic [AW-1:0]   pp;
  logic [PW-1:0]   p_fix;
  logic [XLEN-1:0] rd_fix;
  logic            unused_acc;

  logic s1;
  logic s2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;

  assign s1   = rs1_in[XLEN-1];
  assign s2   = rs2_in[XLEN-1];
  assign mag1 = s1 ? -rs1_in : rs1_in;
  assign mag2 = s2 ? -rs2_in : rs2_in;

  // Magnitudes and result sign for the requested signedness
  always_comb begin
    a1_d  = rs1_in;
    a2_d  = rs2_in;
    neg_d = 1'b0;
    unique case (1'b1)
      (op_in == OP_MULH): begin
        a1_d  = mag1;
        a2_d  = mag2;
        neg_d = s1 ^ s2;
      end
      (op_in == OP_MULHSU): begin
        a1_d  = mag1;
        neg_d = s1;
      end
      default: ;
    endcase
  end

  assign ready_out = ~flush_in &
    ((state_q == S_IDLE) |
     ((state_q == S_DONE) & ready_in));
  assign accept = valid_in & ready_out;
  assign zero   = ~|rs1_in | ~|rs2_in;

  // Low half of a stored product is valid for any signedness
  assign hit = EN_REUSE & re_v_q &
    (rs1_in == re_rs1_q) & (rs2_in == re_rs2_q) &
    ((op_in == OP_MUL) | (op_in == re_op_q));
  assign re_sel = (op_in == OP_MUL) ?
    re_p_q[XLEN-1:0] : re_p_q[PW-1:XLEN];

  assign pp = {{BPC{1'b0}}, m_q} *
              {{PW{1'b0}}, a2_q[BPC-1:0]};

  assign p_fix  = neg_q ? -acc_q[PW-1:0] : acc_q[PW-1:0];
  assign rd_fix = (op_q == OP_MUL) ?
    p_fix[XLEN-1:0] : p_fix[PW-1:XLEN];

  assign unused_acc = ^acc_q[AW-1:PW];

  assign rd_out    = rd_q;
  assign valid_out = vld_q;
  assign busy_out  = (state_q != S_IDLE);

  // Control FSM, shift-add datapath and reuse entry
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      a2_q     <= '0;
      m_q      <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rd_q     <= '0;
      vld_q    <= 1'b0;
      re_v_q   <= 1'b0;
      re_rs1_q <= '0;
      re_rs2_q <= '0;
      re_op_q  <= '0;
      re_p_q   <= '0;
    end else if (flush_in) begin
      state_q <= S_IDLE;
      vld_q   <= 1'b0;
      if ((state_q == S_CALC) | (state_q == S_FIX))
        re_v_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_CALC: begin
          acc_q <= acc_q + pp;
          m_q   <= m_q << BPC;
          a2_q  <= a2_q >> BPC;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1))
            state_q <= S_FIX;
        end
        S_FIX: begin
          rd_q    <= rd_fix;
          vld_q   <= 1'b1;
          state_q <= S_DONE;
          if (EN_REUSE) begin
            re_v_q   <= 1'b1;
            re_rs1_q <= rs1_q;
            re_rs2_q <= rs2_q;
            re_op_q  <= op_q;
            re_p_q   <= p_fix;
          end
        end
        S_DONE: begin
          if (ready_in) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
          end
        end
      endcase
      if (accept) begin
        op_q  <= op_in;
        rs1_q <= rs1_in;
        rs2_q <= rs2_in;
        a2_q  <= a2_d;
        m_q   <= {{XLEN{1'b0}}, a1_d};
        neg_q <= neg_d;
        cnt_q <= '0;
        acc_q <= '0;
        if (zero | hit) begin
          state_q <= S_DONE;
          vld_q   <= 1'b1;
          rd_q    <= zero ? '0 : re_sel;
        end else begin
          state_q <= S_CALC;
          vld_q   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_im_fu_iter.sv
// Scoreboard bench for im_fu_iter: directed corner cases
// followed by random traffic against a product-level model.
module tb_im_fu_iter;

  localparam int XLEN   = 32;
  localparam int BPC    = 4;
  localparam int N      = XLEN / BPC;
  localparam int LAT_IT = N + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_in;
  logic valid_in;
  logic ready_out;
  logic [1:0] op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic valid_out;
  logic ready_in;
  logic [31:0] rd_out;
  logic busy_out;

  im_fu_iter #(
    .XLEN(XLEN),
    .BPC(BPC),
    .EN_REUSE(1'b1)
  ) dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .flush_in(flush_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .op_in(op),
    .rs1_in(rs1),
    .rs2_in(rs2),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .rd_out(rd_out),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] rd;
    int acc;
    int lat;
    bit iter;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit took;

  bit ent_v;
  logic [31:0] ent_a;
  logic [31:0] ent_b;
  logic [1:0] ent_op;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(logic [1:0] o,
      logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (o)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = $signed({{32{a[31]}}, a}) *
                $signed({{32{b[31]}}, b});
      2'd2: p = $signed({{32{a[31]}}, a}) *
                $signed({32'b0, b});
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit exp_ready();
    if (flush_in) return 1'b0;
    if (q.size() == 0) return 1'b1;
    return ((cyc - q[0].acc) >= q[0].lat) && ready_in;
  endfunction

  task automatic push_model();
    exp_t e;
    bit zero;
    bit hit;
    zero = (rs1 == 32'd0) || (rs2 == 32'd0);
    hit = ent_v && (rs1 == ent_a) && (rs2 == ent_b) &&
          ((op == 2'd0) || (op == ent_op));
    e.rd = ref_mul(op, rs1, rs2);
    e.acc = cyc + 1;
    e.iter = !zero && !hit;
    e.lat = e.iter ? LAT_IT : 0;
    if (e.iter) begin
      ent_v = 1'b1;
      ent_a = rs1;
      ent_b = rs2;
      ent_op = op;
    end
    q.push_back(e);
  endtask

  // An op still computing at the flush edge loses the entry
  task automatic flush_model();
    if (q.size() > 0) begin
      if (q[0].iter && (cyc + 1 <= q[0].acc + LAT_IT))
        ent_v = 1'b0;
      void'(q.pop_front());
    end
  endtask

  task automatic drive_cycle();
    bit er;
    took = 1'b0;
    #1;
    er = exp_ready();
    chk("ready_out", 64'(ready_out), 64'(er));
    if (flush_in) flush_model();
    if (valid_in && er) begin
      push_model();
      took = 1'b1;
    end
    @(posedge clk);
    #1;
    if (took) valid_in = 1'b0;
  endtask

  task automatic issue(logic [1:0] o, logic [31:0] a,
                       logic [31:0] b);
    op = o;
    rs1 = a;
    rs2 = b;
    valid_in = 1'b1;
    for (int i = 0; i < 64 && valid_in; i++) drive_cycle();
    if (valid_in) begin
      chk("issue_timeout", 64'(1), 64'(0));
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && q.size() > 0; i++)
      drive_cycle();
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
  endtask

  // Edges after the accepting edge until valid_out shows
  task automatic expect_res(string nm, logic [31:0] er,
                            int el);
    int l = 0;
    while (!valid_out && l < 40) begin
      drive_cycle();
      l++;
    end
    chk({nm, "_lat"}, 64'(l), 64'(el));
    chk(nm, 64'(rd_out), 64'(er));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Result monitor: compares every cycle an op is outstanding
  always @(negedge clk) begin
    if (rst_n && !flush_in) begin
      if (q.size() == 0) begin
        chk("idle_valid", 64'(valid_out), 64'(0));
      end else if (cyc >= q[0].acc) begin
        bit ve;
        ve = (cyc - q[0].acc) >= q[0].lat;
        chk("valid_out", 64'(valid_out), 64'(ve));
        if (ve && valid_out) begin
          chk("rd_out", 64'(rd_out), 64'(q[0].rd));
          if (ready_in) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    logic [31:0] la;
    logic [31:0] lb;
    int ops;
    rst_n = 1'b0;
    flush_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    op = 2'd0;
    rs1 = 32'd0;
    rs2 = 32'd0;
    ent_v = 1'b0;
    ent_a = 32'd0;
    ent_b = 32'd0;
    ent_op = 2'd0;
    la = 32'd3;
    lb = 32'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_out), 64'(0));
    chk("rst_rd", 64'(rd_out), 64'(0));
    chk("rst_busy", 64'(busy_out), 64'(0));
    chk("rst_ready", 64'(ready_out), 64'(1));

    issue(2'd0, 32'd7, 32'hFFFF_FFFD);
    expect_res("mul_7", 32'hFFFF_FFEB, LAT_IT);
    drain();
    issue(2'd1, 32'h8000_0000, 32'h8000_0000);
    expect_res("mulh_min", 32'h4000_0000, LAT_IT);
    drain();
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_res("mulhsu_m1", 32'hFFFF_FFFF, LAT_IT);
    drain();
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_res("mulhu_max", 32'hFFFF_FFFE, LAT_IT);
    drain();

    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    expect_res("mulh_pair",
      ref_mul(2'd1, 32'h1234_5678, 32'h9ABC_DEF0), LAT_IT);
    drain();
    issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    expect_res("mul_reuse", 32'h242D_2080, 0);
    drain();
    issue(2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    expect_res("mulhu_noreuse",
      ref_mul(2'd3, 32'h1234_5678, 32'h9ABC_DEF0), LAT_IT);
    drain();

    issue(2'd0, 32'd3, 32'd5);
    expect_res("mul_3x5_a", 32'd15, LAT_IT);
    drain();
    issue(2'd3, 32'd3, 32'd5);
    drive_cycle();
    drive_cycle();
    flush_in = 1'b1;
    op = 2'd0;
    rs1 = 32'd3;
    rs2 = 32'd5;
    valid_in = 1'b1;
    drive_cycle();
    flush_in = 1'b0;
    chk("flush_took", 64'(took), 64'(0));
    chk("flush_valid", 64'(valid_out), 64'(0));
    chk("flush_busy", 64'(busy_out), 64'(0));
    issue(2'd0, 32'd3, 32'd5);
    expect_res("mul_3x5_b", 32'd15, LAT_IT);
    drain();

    ready_in = 1'b0;
    issue(2'd0, 32'h0000_ABCD, 32'h0000_1357);
    expect_res("hold_res",
      ref_mul(2'd0, 32'h0000_ABCD, 32'h0000_1357), LAT_IT);
    for (int i = 0; i < 4; i++) begin
      drive_cycle();
      chk("hold_valid", 64'(valid_out), 64'(1));
      chk("hold_rd", 64'(rd_out),
        64'(ref_mul(2'd0, 32'h0000_ABCD, 32'h0000_1357)));
    end
    ready_in = 1'b1;
    op = 2'd3;
    rs1 = 32'h0000_ABCD;
    rs2 = 32'h0000_1357;
    valid_in = 1'b1;
    drive_cycle();
    chk("b2b_took", 64'(took), 64'(1));
    chk("b2b_busy", 64'(busy_out), 64'(1));
    chk("b2b_valid", 64'(valid_out), 64'(0));
    expect_res("b2b_res",
      ref_mul(2'd3, 32'h0000_ABCD, 32'h0000_1357), LAT_IT);
    drain();

    issue(2'd1, 32'h0000_1234, 32'h0000_5678);
    drive_cycle();
    drive_cycle();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 64'(valid_out), 64'(0));
    chk("mid_rst_rd", 64'(rd_out), 64'(0));
    chk("mid_rst_busy", 64'(busy_out), 64'(0));
    q.delete();
    ent_v = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy_out), 64'(0));
    chk("post_rst_ready", 64'(ready_out), 64'(1));

    ops = 0;
    for (int c = 0; c < 60000 && ops < 3000; c++) begin
      ready_in = ($urandom_range(0, 3) != 0);
      flush_in = ($urandom_range(0, 59) == 0);
      if (!valid_in && $urandom_range(0, 2) != 0) begin
        op = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          rs1 = la;
          rs2 = lb;
        end else begin
          rs1 = pick();
          rs2 = pick();
        end
        la = rs1;
        lb = rs2;
        valid_in = 1'b1;
      end
      drive_cycle();
      if (took) ops++;
    end
    flush_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    drain();
    chk("random_ops", 64'(ops), 64'(3000));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
